spi_to_axis_bridge: RTL and testbench

//  Packs a burst of bytes from the SPI master read port into one wide AXI4-Stream beat.

---
 rtl/spi_to_axis_bridge_packer.sv | 50 +++++
 rtl/spi_to_axis_bridge.sv | 62 ++++++
 tb/tb_spi_to_axis_bridge.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_to_axis_bridge_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_frame_packer
// Description : Collects NUM_BYTES strobed bytes into one frame, first byte in
//               the MSBs. Flags the strobe that completes a frame and presents
//               the completed frame (including that byte) combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_frame_packer #(
    parameter int NUM_BYTES = 13,
    parameter int BYTE_W    = 8,
    localparam int TDATA_W  = NUM_BYTES * BYTE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [BYTE_W-1:0]  i_data,
    output logic               o_frame_done,
    output logic [TDATA_W-1:0] o_frame_data
);

    localparam int               c_CNT_W    = $clog2(NUM_BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_BYTES - 1);

    // Only the older NUM_BYTES-1 bytes need storage; the newest byte comes
    // straight from the input when the frame completes.
    logic [TDATA_W-BYTE_W-1:0] r_shift;
    logic [c_CNT_W-1:0]        r_count;
    logic [TDATA_W-1:0]        w_next_shift;
    logic                      w_last;

    assign w_next_shift = {r_shift, i_data};
    assign w_last       = (r_count == c_LAST_IDX);

    assign o_frame_done = i_valid && w_last;
    assign o_frame_data = w_next_shift;

    // Shift in one byte per strobe and wrap the byte counter at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_valid) begin
            r_shift <= w_next_shift[TDATA_W-BYTE_W-1:0];
            r_count <= w_last ? '0 : r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_to_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_to_axis_bridge
// Description : Packs a burst of SPI read bytes into one wide AXI4-Stream
//               beat. Assembly is double-buffered from the output register so
//               the next frame is collected while a beat waits for TREADY.
//               Frames completing while the output slot is held are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_to_axis_bridge #(
    parameter int NUM_BYTES = 13,
    parameter int BYTE_W    = 8,
    localparam int TDATA_W  = NUM_BYTES * BYTE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read_ready,
    input  logic [BYTE_W-1:0]  read_data,
    input  logic               TREADY,
    output logic               TVALID,
    output logic [TDATA_W-1:0] TDATA
);

    logic               w_frame_done;
    logic [TDATA_W-1:0] w_frame_data;
    logic               w_slot_free;
    logic               r_tvalid;
    logic [TDATA_W-1:0] r_tdata;

    byte_frame_packer #(
        .NUM_BYTES (NUM_BYTES),
        .BYTE_W    (BYTE_W)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (read_ready),
        .i_data       (read_data),
        .o_frame_done (w_frame_done),
        .o_frame_data (w_frame_data)
    );

    // The slot can take a new frame if empty or being drained this cycle.
    assign w_slot_free = !r_tvalid || TREADY;

    // AXIS output register: load on frame completion when free, else drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (w_frame_done && w_slot_free) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_frame_data;
        end else if (r_tvalid && TREADY) begin
            r_tvalid <= 1'b0;
        end
    end

    assign TVALID = r_tvalid;
    assign TDATA  = r_tdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_to_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_to_axis_bridge
// Description : Directed self-checking bench for spi_to_axis_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_to_axis_bridge;

    localparam int c_W = 104;

    logic           clk;
    logic           reset;
    logic           read_ready;
    logic [7:0]     read_data;
    logic           TREADY;
    logic           TVALID;
    logic [c_W-1:0] TDATA;

    int             n_checks;
    int             n_errors;
    logic [c_W-1:0] acc_q[$];
    int             vcycles;

    spi_to_axis_bridge #(
        .NUM_BYTES (13),
        .BYTE_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_ready (read_ready),
        .read_data  (read_data),
        .TREADY     (TREADY),
        .TVALID     (TVALID),
        .TDATA      (TDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted beats and valid-high cycles, sampled after inputs settle.
    always @(negedge clk) begin
        #1;
        if (TVALID === 1'b1) vcycles++;
        if (TVALID === 1'b1 && TREADY === 1'b1) acc_q.push_back(TDATA);
    end

    task automatic check_eq(input string tag, input logic [c_W-1:0] got,
                            input logic [c_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame built from 13 consecutive byte values starting at base.
    function automatic logic [c_W-1:0] frame_of(input logic [7:0] base);
        logic [c_W-1:0] f;
        f = '0;
        for (int i = 0; i < 13; i++) f = {f[c_W-9:0], 8'(base + 8'(i))};
        return f;
    endfunction

    // One-cycle strobe; returns at the negedge just after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        read_ready = 1'b1;
        read_data  = b;
        @(negedge clk);
        read_ready = 1'b0;
        read_data  = 8'h00;
    endtask

    // 13 strobes, one idle cycle between each.
    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < 13; i++) send_byte(8'(base + 8'(i)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int q0;
    int v0;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        vcycles    = 0;
        reset      = 1'b0;
        read_ready = 1'b0;
        read_data  = 8'h00;
        TREADY     = 1'b0;

        // 1: reset state and idle
        idle(3);
        check_eq("rst_tvalid", c_W'(TVALID), c_W'(0));
        check_eq("rst_tdata", TDATA, c_W'(0));
        reset = 1'b1;
        idle(5);
        check_eq("idle_tvalid", c_W'(TVALID), c_W'(0));

        // 2: single frame, TREADY=1
        TREADY = 1'b1;
        q0 = acc_q.size();
        v0 = vcycles;
        send_frame(8'h00);
        check_eq("s2_tvalid", c_W'(TVALID), c_W'(1));
        check_eq("s2_tdata", TDATA, 104'h000102030405060708090A0B0C);
        idle(1);
        check_eq("s2_pulse_end", c_W'(TVALID), c_W'(0));
        idle(2);
        check_eq("s2_beats", c_W'(acc_q.size() - q0), c_W'(1));
        check_eq("s2_vcycles", c_W'(vcycles - v0), c_W'(1));

        // 3: back-to-back frames
        q0 = acc_q.size();
        v0 = vcycles;
        send_frame(8'h00);
        check_eq("s3_tdata0", TDATA, 104'h000102030405060708090A0B0C);
        send_frame(8'h00);
        check_eq("s3_tdata1", TDATA, 104'h000102030405060708090A0B0C);
        idle(3);
        check_eq("s3_beats", c_W'(acc_q.size() - q0), c_W'(2));
        check_eq("s3_vcycles", c_W'(vcycles - v0), c_W'(2));
        check_eq("s3_beat0", acc_q[q0], 104'h000102030405060708090A0B0C);
        check_eq("s3_beat1", acc_q[q0 + 1], 104'h000102030405060708090A0B0C);

        // 4: backpressure
        TREADY = 1'b0;
        q0 = acc_q.size();
        send_frame(8'h10);
        check_eq("s4_tvalid", c_W'(TVALID), c_W'(1));
        check_eq("s4_tdata", TDATA, 104'h101112131415161718191A1B1C);
        idle(4);
        check_eq("s4_hold_valid", c_W'(TVALID), c_W'(1));
        check_eq("s4_hold_data", TDATA, 104'h101112131415161718191A1B1C);
        TREADY = 1'b1;
        idle(1);
        check_eq("s4_accept", c_W'(TVALID), c_W'(0));
        check_eq("s4_beats", c_W'(acc_q.size() - q0), c_W'(1));
        check_eq("s4_beat", acc_q[q0], 104'h101112131415161718191A1B1C);

        // 5: overflow
        TREADY = 1'b0;
        q0 = acc_q.size();
        send_frame(8'h10);
        send_frame(8'h20);
        check_eq("s5_keepA_valid", c_W'(TVALID), c_W'(1));
        check_eq("s5_keepA_data", TDATA, 104'h101112131415161718191A1B1C);
        TREADY = 1'b1;
        idle(1);
        check_eq("s5_drain", c_W'(TVALID), c_W'(0));
        idle(3);
        check_eq("s5_beats", c_W'(acc_q.size() - q0), c_W'(1));
        check_eq("s5_beatA", acc_q[q0], 104'h101112131415161718191A1B1C);
        send_frame(8'h40);
        check_eq("s5_C_valid", c_W'(TVALID), c_W'(1));
        check_eq("s5_C_data", TDATA, frame_of(8'h40));

        // 6: reset mid-frame with a pending beat
        idle(2);
        TREADY = 1'b0;
        send_frame(8'h60);
        check_eq("s6_pending", c_W'(TVALID), c_W'(1));
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + 8'(i)));
        reset = 1'b0;
        #1;
        check_eq("s6_rst_valid", c_W'(TVALID), c_W'(0));
        check_eq("s6_rst_data", TDATA, c_W'(0));
        idle(2);
        reset  = 1'b1;
        TREADY = 1'b1;
        send_frame(8'h30);
        check_eq("s6_valid", c_W'(TVALID), c_W'(1));
        check_eq("s6_data", TDATA, 104'h303132333435363738393A3B3C);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
